// File: rtl/glitc_dac_i2c_sequencer.sv
// rtl/glitc_dac_i2c_sequencer.sv - pushes pending Vped DAC settings to two quad I2C DACs via the OpenCores I2C master
// Optional: define GLITC_DAC_RETRY_EN to retry a frame once (after STOP and a 256-clock wait) on its first NACK.
module glitc_dac_i2c_sequencer #(
    parameter logic [6:0]  DAC0_ADDR    = 7'h60,
    parameter logic [6:0]  DAC1_ADDR    = 7'h61,
    parameter logic [15:0] PRESCALE     = 16'd99,
    parameter logic [15:0] POLL_TIMEOUT = 16'd50000
) (
    input  logic        user_clk_i,
    input  logic        user_rst_i,
    input  logic [7:0]  dac_pending_i,
    input  logic [95:0] dac_value_i,
    input  logic [7:0]  dac_eeprom_i,
    input  logic        pause_i,
    output logic [7:0]  dac_done_o,
    output logic        busy_o,
    output logic        init_done_o,
    output logic        error_o,
    output logic [7:0]  error_code_o,
    output logic [2:0]  wb_adr_o,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);
    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_WR_TXR, S_WR_CR, S_POLL, S_CHECK,
        S_STOP_CR, S_STOP_POLL, S_RETRY_WAIT, S_FIN
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_cyc, r_eep, r_nack, r_busy, r_init_done, r_err;
    logic [1:0]  r_byte, r_code;
    logic [2:0]  r_ch;
    logic [11:0] r_val;
    logic [15:0] r_poll_cnt;
    logic [7:0]  r_done, r_err_code;
    logic        w_acc, w_we, w_ack, w_tip, w_rxack, w_expired, w_retry_go, w_sel_eep, w_unused;
    logic [2:0]  w_adr, w_sel;
    logic [7:0]  w_dat, w_tx_byte, w_cr_byte;
    logic [11:0] w_sel_val;
`ifdef GLITC_DAC_RETRY_EN
    logic        r_retried, r_retry_go;
    logic [7:0]  r_wait;
    assign w_retry_go = r_retry_go;
`else
    assign w_retry_go = 1'b0;
`endif

    assign w_ack     = r_cyc & wb_ack_i;
    assign w_tip     = wb_dat_i[1];
    assign w_rxack   = wb_dat_i[7];
    assign w_unused  = ^{wb_dat_i[6:2], wb_dat_i[0]};
    assign w_expired = (r_poll_cnt == POLL_TIMEOUT);

    // Lowest pending index wins: scan downward so the last match is the smallest.
    always_comb begin
        w_sel     = '0;
        w_sel_val = '0;
        w_sel_eep = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (dac_pending_i[i]) begin
                w_sel     = 3'(i);
                w_sel_val = dac_value_i[12*i +: 12];
                w_sel_eep = dac_eeprom_i[i];
            end
        end
    end

    always_comb begin
        case (r_byte)
            2'd0:    w_tx_byte = {(r_ch[2] ? DAC1_ADDR : DAC0_ADDR), 1'b0};
            2'd1:    w_tx_byte = (r_eep ? 8'h58 : 8'h40) | {5'b0, r_ch[1:0], 1'b0};
            2'd2:    w_tx_byte = {4'b0000, r_val[11:8]};
            default: w_tx_byte = r_val[7:0];
        endcase
        case (r_byte)
            2'd0:    w_cr_byte = 8'h90;
            2'd3:    w_cr_byte = 8'h50;
            default: w_cr_byte = 8'h10;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc       = 1'b0;
        w_we        = 1'b0;
        w_adr       = 3'd0;
        w_dat       = 8'h00;
        case (r_state)
            S_INIT: begin
                w_acc = 1'b1;
                w_we  = 1'b1;
                w_adr = {1'b0, r_byte};
                w_dat = (r_byte == 2'd0) ? PRESCALE[7:0] : (r_byte == 2'd1) ? PRESCALE[15:8] : 8'h80;
                if (w_ack && r_byte == 2'd2) w_state_nxt = S_IDLE;
            end
            // A done pulse still on the output means upstream has not yet cleared that pending bit.
            S_IDLE: if (!pause_i && |dac_pending_i && r_done == '0) w_state_nxt = S_WR_TXR;
            S_WR_TXR: begin
                w_acc = 1'b1;
                w_we  = 1'b1;
                w_adr = 3'd3;
                w_dat = w_tx_byte;
                if (w_ack) w_state_nxt = S_WR_CR;
            end
            S_WR_CR: begin
                w_acc = 1'b1;
                w_we  = 1'b1;
                w_adr = 3'd4;
                w_dat = w_cr_byte;
                if (w_ack) w_state_nxt = S_POLL;
            end
            S_POLL: begin
                w_acc = !w_expired;
                w_adr = 3'd4;
                if (!r_cyc && w_expired)  w_state_nxt = S_STOP_CR;
                else if (w_ack && !w_tip) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (r_nack)               w_state_nxt = S_STOP_CR;
                else if (r_byte == 2'd3)  w_state_nxt = S_FIN;
                else                      w_state_nxt = S_WR_TXR;
            end
            S_STOP_CR: begin
                w_acc = 1'b1;
                w_we  = 1'b1;
                w_adr = 3'd4;
                w_dat = 8'h40;
                if (w_ack) w_state_nxt = (r_code == 2'b10) ? S_FIN : S_STOP_POLL;
            end
            S_STOP_POLL: begin
                w_acc = !w_expired;
                w_adr = 3'd4;
                if ((!r_cyc && w_expired) || (w_ack && !w_tip))
                    w_state_nxt = w_retry_go ? S_RETRY_WAIT : S_FIN;
            end
`ifdef GLITC_DAC_RETRY_EN
            S_RETRY_WAIT: if (r_wait == 8'hFF) w_state_nxt = S_WR_TXR;
`endif
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge user_clk_i) begin
        if (user_rst_i) begin
            r_state     <= S_INIT;
            r_cyc       <= 1'b0;
            r_byte      <= '0;
            r_ch        <= '0;
            r_val       <= '0;
            r_eep       <= 1'b0;
            r_nack      <= 1'b0;
            r_code      <= '0;
            r_poll_cnt  <= '0;
            r_busy      <= 1'b0;
            r_init_done <= 1'b0;
            r_done      <= '0;
            r_err       <= 1'b0;
            r_err_code  <= '0;
`ifdef GLITC_DAC_RETRY_EN
            r_retried   <= 1'b0;
            r_retry_go  <= 1'b0;
            r_wait      <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_done  <= '0;
            r_err   <= 1'b0;
            // Launching only from an idle bus leaves one dead cycle between accesses.
            if (r_cyc) begin
                if (wb_ack_i) r_cyc <= 1'b0;
            end else if (w_acc) begin
                r_cyc <= 1'b1;
            end
            if (r_state == S_POLL || r_state == S_STOP_POLL) begin
                if (!w_expired) r_poll_cnt <= r_poll_cnt + 16'd1;
            end else begin
                r_poll_cnt <= '0;
            end
            case (r_state)
                S_INIT: if (w_ack) begin
                    if (r_byte == 2'd2) begin
                        r_byte      <= 2'd0;
                        r_init_done <= 1'b1;
                    end else begin
                        r_byte <= r_byte + 2'd1;
                    end
                end
                S_IDLE: if (w_state_nxt == S_WR_TXR) begin
                    r_ch       <= w_sel;
                    r_val      <= w_sel_val;
                    r_eep      <= w_sel_eep;
                    r_busy     <= 1'b1;
                    r_byte     <= 2'd0;
                    r_code     <= 2'b00;
                    r_nack     <= 1'b0;
`ifdef GLITC_DAC_RETRY_EN
                    r_retried  <= 1'b0;
                    r_retry_go <= 1'b0;
`endif
                end
                S_POLL: begin
                    if (!r_cyc && w_expired)  r_code <= 2'b10;
                    else if (w_ack && !w_tip) r_nack <= w_rxack;
                end
                S_CHECK: begin
                    if (r_nack) begin
                        r_nack <= 1'b0;
`ifdef GLITC_DAC_RETRY_EN
                        if (!r_retried) r_retry_go <= 1'b1;
                        else            r_code     <= 2'b11;
`else
                        r_code <= 2'b01;
`endif
                    end else if (r_byte != 2'd3) begin
                        r_byte <= r_byte + 2'd1;
                    end
                end
`ifdef GLITC_DAC_RETRY_EN
                S_RETRY_WAIT: begin
                    r_wait <= r_wait + 8'd1;
                    if (r_wait == 8'hFF) begin
                        r_byte     <= 2'd0;
                        r_retried  <= 1'b1;
                        r_retry_go <= 1'b0;
                    end
                end
`endif
                S_FIN: begin
                    r_done <= 8'(1) << r_ch;
                    r_busy <= 1'b0;
                    if (r_code != 2'b00) begin
                        r_err      <= 1'b1;
                        r_err_code <= {r_ch, 3'b000, r_code};
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_cyc_o     = r_cyc;
    assign wb_stb_o     = r_cyc;
    assign wb_we_o      = r_cyc & w_we;
    assign wb_adr_o     = r_cyc ? w_adr : 3'd0;
    assign wb_dat_o     = r_cyc ? w_dat : 8'h00;
    assign dac_done_o   = r_done;
    assign busy_o       = r_busy;
    assign init_done_o  = r_init_done;
    assign error_o      = r_err;
    assign error_code_o = r_err_code;
endmodule
